// File: rtl/seq_unrotator.sv
// Multi-cycle inverse rotator: undoes a forward rotate by stepping one bit per
// clock in the opposite direction, with a start/busy/done handshake.
module seq_unrotator #(
  parameter int DATA_WIDTH = 8,
  parameter int AMT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [AMT_WIDTH-1:0]  amt,
  input  logic                  choice,
  output logic                  busy,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = a;
          cnt_d   = amt;
          dir_d   = choice;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // dir_q=1 means the forward rotator went right, so step back left.
        if (dir_q) begin
          data_d = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
        end else begin
          data_d = {data_q[0], data_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q - AMT_WIDTH'(1);
        if (cnt_q == AMT_WIDTH'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Publish the result only as DONE is entered so partial rotations stay hidden.
    if (state_d == DONE && state_q != DONE) begin
      y_d = data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign ready = ~busy;
  assign done  = (state_q == DONE);
  assign y     = y_q;

endmodule

// File: tb/tb_seq_unrotator.sv
// Randomised and exhaustive round-trip bench for seq_unrotator against a
// word-level rotate model.
module tb_seq_unrotator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       choice;
  logic       busy, ready, done;
  logic [7:0] y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_y;

  seq_unrotator #(.DATA_WIDTH(8), .AMT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .amt(amt),
    .choice(choice), .busy(busy), .ready(ready), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word rotate by n: left when left=1, else right.
  function automatic logic [7:0] rot(input logic [7:0] x, input int n, input logic left);
    logic [15:0] t;
    t = {x, x};
    if (left) begin
      t = t << n;
      return t[15:8];
    end
    t = t >> n;
    return t[7:0];
  endfunction

  // One operation; inputs are scrambled while busy, optionally with a stray start.
  task automatic run_op(input logic [7:0] ai, input int am, input logic ch,
                        input logic [7:0] exp, input bit noise, input bit verbose);
    int lat, ndone, nbusy, nk;
    bit hold_ok, rdy_ok;
    logic [7:0] y_at_done;
    nk = noise ? int'($urandom_range(am + 1, 1)) : 0;
    @(negedge clk);
    start = 1'b1; a = ai; amt = am[2:0]; choice = ch;
    lat = 0; ndone = 0; nbusy = 0; hold_ok = 1; rdy_ok = 1; y_at_done = 8'h00;
    for (int k = 1; k <= am + 3; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = k;
          y_at_done = y;
        end
      end
      if (busy) nbusy++;
      if (ready !== ~busy) rdy_ok = 0;
      if (lat == 0 && y !== prev_y) hold_ok = 0;
      start  = (k == nk);
      a      = 8'($urandom);
      amt    = 3'($urandom);
      choice = 1'($urandom);
    end
    start = 1'b0;
    check("latency", lat, am + 1);
    check("y_result", y_at_done, exp);
    check("done_count", ndone, 1);
    check("busy_cycles", nbusy, am + 1);
    check("y_held_during_op", hold_ok, 1);
    check("ready_eq_not_busy", rdy_ok, 1);
    check("y_after_done", y, exp);
    check("popcount", $countones(y_at_done), $countones(ai));
    if (verbose)
      $display("op a=%02h amt=%0d choice=%0d -> y=%02h lat=%0d (exp %02h)",
               ai, am, ch, y_at_done, lat, exp);
    prev_y = exp;
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; a = 8'h00; amt = 3'd0; choice = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_y", y, 8'h00);
    check("reset_done", done, 0);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    prev_y = 8'h00;

    run_op(8'hB4, 3, 1'b1, rot(8'hB4, 3, 1'b1), 0, 1);
    run_op(8'h3C, 2, 1'b0, rot(8'h3C, 2, 1'b0), 0, 1);
    run_op(8'h5A, 0, 1'b0, rot(8'h5A, 0, 1'b0), 0, 1);
    run_op(8'h81, 7, 1'b1, rot(8'h81, 7, 1'b1), 1, 1);

    // Abort during the third SHIFT cycle.
    @(negedge clk);
    start = 1'b1; a = 8'hB4; amt = 3'd5; choice = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_y", y, 8'h00);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    $display("abort: y=%02h ready=%0d", y, ready);
    prev_y = 8'h00;
    run_op(8'hB4, 5, 1'b1, rot(8'hB4, 5, 1'b1), 0, 1);

    // Round trip: forward-rotate each word, require the block to restore it.
    for (int w = 0; w < 256; w++) begin
      for (int am = 0; am < 8; am++) begin
        for (int ch = 0; ch < 2; ch++) begin
          run_op(rot(8'(w), am, ch == 0), am, 1'(ch), 8'(w), $urandom_range(3, 0) == 0, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
